// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fadd_cell.sv
// Gate-level one-bit full adder, reused every cycle by the serial controller.
module fadd_cell (
    output logic S,
    output logic C,
    input  logic a,
    input  logic b,
    input  logic c
);

    logic w_p;
    logic w_g;
    logic w_t;

    xor g_xor_p (w_p, a, b);
    xor g_xor_s (S, w_p, c);
    and g_and_g (w_g, a, b);
    and g_and_t (w_t, w_p, c);
    or  g_or_c  (C, w_g, w_t);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB-first, one bit per clock,
// with a carry flip-flop chaining positions and a one-cycle done pulse.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum_sr;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_s;
    logic               w_c;

    fadd_cell u_cell (
        .S (w_s),
        .C (w_c),
        .a (r_a[0]),
        .b (r_b[0]),
        .c (r_carry)
    );

    // NOTE: all state updates use <= so every register samples pre-edge values,
    // which is what lets the shift regs and the carry advance in lockstep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sum_sr <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_carry  <= cin;
                        r_sum_sr <= '0;
                        r_cnt    <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_a      <= {1'b0, r_a[WIDTH-1:1]};
                    r_b      <= {1'b0, r_b[WIDTH-1:1]};
                    r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
                    r_carry  <= w_c;
                    if (r_cnt == LAST_BIT) begin
                        // Publish on the edge entering DONE so the result is
                        // already stable for the whole done cycle.
                        r_sum   <= {w_s, r_sum_sr[WIDTH-1:1]};
                        r_cout  <= w_c;
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == RUN) || (r_state == DONE);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] prev_sum;
    logic       prev_cout;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done8(output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!done8 && edges < 40);
        check("done8_timeout", {31'd0, done8}, 32'd1);
    endtask

    // One WIDTH=8 operation; edges are counted from the acceptance edge.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] exp_sum, input logic exp_cout);
        int edges;
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check({tag, "_busy"}, {31'd0, busy8}, 32'd1);
        check({tag, "_hold"}, {23'd0, cout8, sum8}, {23'd0, prev_cout, prev_sum});
        wait_done8(edges);
        check({tag, "_lat"}, edges, 32'd8);
        check({tag, "_res"}, {23'd0, cout8, sum8}, {23'd0, exp_cout, exp_sum});
        tick();
        check({tag, "_pulse"}, {30'd0, busy8, done8}, 32'd0);
        check({tag, "_keep"}, {23'd0, cout8, sum8}, {23'd0, exp_cout, exp_sum});
        prev_sum  = exp_sum;
        prev_cout = exp_cout;
    endtask

    initial begin
        int edges;
        int last_edge;
        int now_edge;
        logic [2:0] exp2;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        prev_sum = 8'h00; prev_cout = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_busy", {31'd0, busy8}, 32'd0);
        check("reset_done", {31'd0, done8}, 32'd0);
        check("reset_sum",  {24'd0, sum8},  32'd0);
        check("reset_cout", {31'd0, cout8}, 32'd0);

        run8("zero",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        run8("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run8("alt",    8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        run8("mixed",  8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
        run8("msb",    8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);

        // Start re-pulsed with new operands mid-run must not disturb the op.
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("restart_busy", {31'd0, busy8}, 32'd1);
        edges = 4;
        do begin
            tick();
            edges++;
        end while (!done8 && edges < 40);
        check("restart_lat", edges, 32'd8);
        check("restart_res", {23'd0, cout8, sum8}, {23'd0, 1'b0, 8'h47});
        tick();
        tick();
        check("restart_noqueue", {31'd0, busy8}, 32'd0);

        // Start held high: back-to-back results every WIDTH+2 edges.
        a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
        wait_done8(edges);
        check("b2b_res1", {23'd0, cout8, sum8}, {23'd0, 1'b0, 8'h4B});
        a8 = 8'hFF; b8 = 8'h01;
        wait_done8(edges);
        start8 = 1'b0;
        check("b2b_period", edges, 32'd10);
        check("b2b_res2", {23'd0, cout8, sum8}, {23'd0, 1'b1, 8'h00});
        repeat (2) tick();

        // Reset in RUN bit 4, with a start sampled on the same edge.
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        rst = 1'b1; start8 = 1'b1;
        tick();
        rst = 1'b0; start8 = 1'b0;
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_sum",  {24'd0, sum8},  32'd0);
        check("rst_cout", {31'd0, cout8}, 32'd0);
        tick();
        check("rst_start_dropped", {31'd0, busy8}, 32'd0);
        prev_sum = 8'h00; prev_cout = 1'b0;
        run8("after_rst", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);

        // WIDTH=2 exhaustive with start held high.
        start2 = 1'b1;
        now_edge = 0;
        last_edge = 0;
        for (int i = 0; i < 32; i++) begin
            a2 = i[1:0]; b2 = i[3:2]; cin2 = i[4];
            exp2 = {1'b0, a2} + {1'b0, b2} + {2'b00, cin2};
            edges = 0;
            do begin
                tick();
                edges++;
                now_edge++;
            end while (!done2 && edges < 20);
            check($sformatf("w2_timeout_%0d", i), {31'd0, done2}, 32'd1);
            check($sformatf("w2_res_%0d", i), {29'd0, cout2, sum2}, {29'd0, exp2});
            if (i > 0)
                check($sformatf("w2_period_%0d", i), now_edge - last_edge, 32'd4);
            last_edge = now_edge;
        end
        start2 = 1'b0;
        repeat (3) tick();
        check("w2_idle", {31'd0, busy2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that sequences a single one-bit full-adder cell to add two WIDTH-bit operands LSB-first, one bit per clock. It sits between a requester issuing start-with-operands and a consumer sampling the result on a one-cycle done pulse. The cell is reused every cycle, and a carry flip-flop chains bit positions. This trades latency for area against a WIDTH-wide ripple adder.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; one clock domain for the whole block.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; sum and cout are valid.
- sum  output  WIDTH  result a+b+cin, low WIDTH bits.
- cout  output  1  carry out of bit WIDTH-1.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads shift regs A<=a and B<=b, carry<=cin, bit counter<=0, and moves to RUN.
  - start=0 stays in IDLE.
- RUN, per cycle:
  - The cell computes s,c from A[0], B[0], carry.
  - The sum shift reg shifts right with s entering at the MSB. A and B shift right with zero fill.
  - carry<=c; counter increments.
  - When counter==WIDTH-1, the final bit is processed and the state moves to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - sum<=sum shift reg; cout<=carry; both are already final on entry to DONE.
  - Returns to IDLE unconditionally.
- Arithmetic: {cout,sum} == a+b+cin computed at WIDTH+1 bits; wrap-around is expressed only through cout.
- start in RUN or DONE is ignored. No queueing; the requester must re-assert start in IDLE.
- Operand changes after capture have no effect on the running operation.
- sum and cout hold their last result until the next operation reaches DONE.
- Counter width is $clog2(WIDTH). Counter values above WIDTH-1 are unreachable.

## Timing
- Reset values: state IDLE, busy=0, done=0, sum=0, cout=0; internal shift regs, carry and counter are 0.
- rst overrides everything, including rst asserted mid-RUN. On the next edge the state goes to IDLE and all outputs return to their reset values. A start sampled in the same cycle as rst is dropped.
- Latency, with start accepted at edge k:
  - busy=1 from edge k.
  - WIDTH RUN cycles follow.
  - done=1 in the cycle following edge k+WIDTH, which is WIDTH+1 cycles after acceptance.
  - busy falls at edge k+WIDTH+1.
- Throughput: one addition per WIDTH+2 cycles. A start held high continuously is accepted in IDLE on the cycle after DONE.
- sum and cout are registered outputs. They change only at the edge entering DONE and are stable while done=1.
- busy and done are decoded from the state register and are glitch-free registered decodes.

## Structure
- Package serial_add_pkg holds:
  - the state enum: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - a localparam for the default WIDTH.
- Sub-module fadd_cell(S,C,a,b,c) is a gate-level one-bit full adder (two xor, two and, one or), instantiated once inside serial_add_ctrl.
- The top module holds the FSM, operand shift regs, sum shift reg, carry flip-flop and bit counter.

## Test plan
- After reset with WIDTH=8, check busy=0, done=0, sum=8'h00, cout=0. Then apply a=8'h00, b=8'h00, cin=0 with start pulsed once -> done pulse exactly 9 cycles after acceptance with sum=8'h00 and cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (full carry ripple through all bits).
- a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1. Also a=8'h3C, b=8'h0F, cin=0 -> sum=8'h4B, cout=0.
- start re-pulsed and a/b changed during RUN -> no restart and the first result is unchanged. Also start held high -> back-to-back results with a period of 10 cycles.
- rst asserted at RUN bit 4 -> next cycle busy=0, done=0, sum=0, cout=0. A following start completes correctly.
- WIDTH=2 exhaustive run over all 32 combinations of a, b and cin -> {cout,sum}==a+b+cin, with done every 4 cycles when start is held high.
